// File: rtl/hcount_source.sv
// Traffic generator driving one 4-phase req/ack channel with an incrementing data sequence.
// The raw ack is debounced before the FSM sees it.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 2
`endif

// state | meaning
// INIT  | first cycle after reset, raises rdy
// LOAD  | data ready, waiting for debounced ack low before raising req
// REQ   | req high, waiting for debounced ack high
// REL   | req low, waiting for debounced ack low; completes the handshake
// DONE  | NUM_MSGS handshakes completed, outputs frozen until reset
module hcount_source #(
   parameter int ASZ       = `NS_ADDRESS_SIZE,
   parameter int DSZ       = `NS_DATA_SIZE,
   parameter int RSZ       = `NS_REDUN_SIZE,
   parameter int MY_ADDR   = 0,
   parameter int DST_ADDR  = 1,
   parameter int START_DAT = 0,
   parameter int NUM_MSGS  = 4,
   parameter int CSZ       = 16,
   parameter int ACK_CKS   = `NS_REQ_CKS
) (
   input  logic           gch_clk,
   input  logic           gch_reset,
   output logic           gch_ready,
   output logic           snd0_req,
   input  logic           snd0_ack,
   output logic [ASZ-1:0] snd0_src,
   output logic [ASZ-1:0] snd0_dst,
   output logic [DSZ-1:0] snd0_dat,
   output logic [RSZ-1:0] snd0_red,
   output logic           o_done,
   output logic [CSZ-1:0] o_count
);

   localparam int            RW       = $clog2(ACK_CKS + 1);
   localparam logic [RW-1:0] REM_RST  = RW'(ACK_CKS);
   localparam logic [RW-1:0] REM_CHG  = RW'(ACK_CKS - 1);
   localparam logic [DSZ-1:0] DAT_INIT = DSZ'(START_DAT);
   localparam logic [CSZ-1:0] NUM_C    = CSZ'(NUM_MSGS);

   typedef enum logic [2:0] {S_INIT, S_LOAD, S_REQ, S_REL, S_DONE} state_t;

   state_t         state, state_nxt;
   logic           req_nxt, rdy, rdy_nxt, done_nxt;
   logic [DSZ-1:0] dat_nxt;
   logic [CSZ-1:0] count_nxt, count_inc;

   logic           ack_last, ack_last_nxt;
   logic [RW-1:0]  ack_rem, ack_rem_nxt;
   logic           ckd_ack, ckd_ack_nxt;
   logic           settled, settled_nxt;

   // ack_rem is a down-counter of matching samples still needed; reset needs a full ACK_CKS run
   always_comb begin
      ack_last_nxt = ack_last;
      ack_rem_nxt  = ack_rem;
      ckd_ack_nxt  = ckd_ack;
      settled_nxt  = settled;
      if (snd0_ack != ack_last) begin
         ack_last_nxt = snd0_ack;
         ack_rem_nxt  = REM_CHG;
         if (ACK_CKS == 1) begin
            ckd_ack_nxt = snd0_ack;
            settled_nxt = 1'b1;
         end
      end else if (ack_rem > RW'(1)) begin
         ack_rem_nxt = ack_rem - 1'b1;
      end else begin
         ack_rem_nxt = '0;
         ckd_ack_nxt = snd0_ack;
         settled_nxt = 1'b1;
      end
   end

   always_ff @(posedge gch_clk) begin
      if (gch_reset) begin
         ack_last <= 1'b0;
         ack_rem  <= REM_RST;
         ckd_ack  <= 1'b0;
         settled  <= 1'b0;
      end else begin
         ack_last <= ack_last_nxt;
         ack_rem  <= ack_rem_nxt;
         ckd_ack  <= ckd_ack_nxt;
         settled  <= settled_nxt;
      end
   end

   assign count_inc = o_count + 1'b1;

   always_comb begin
      state_nxt = state;
      req_nxt   = snd0_req;
      rdy_nxt   = rdy;
      done_nxt  = o_done;
      dat_nxt   = snd0_dat;
      count_nxt = o_count;
      case (state)
         S_INIT: begin
            rdy_nxt   = 1'b1;
            state_nxt = S_LOAD;
         end
         // Uses the debouncer's decision for this edge so a stuck-high ack seen since
         // reset is never mistaken for the cleared low value.
         S_LOAD: begin
            if (settled_nxt && !ckd_ack_nxt) begin
               req_nxt   = 1'b1;
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (ckd_ack) begin
               req_nxt   = 1'b0;
               state_nxt = S_REL;
            end
         end
         S_REL: begin
            if (!ckd_ack) begin
               count_nxt = count_inc;
               dat_nxt   = snd0_dat + 1'b1;
               if (NUM_MSGS != 0 && count_inc == NUM_C) begin
                  done_nxt  = 1'b1;
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_LOAD;
               end
            end
         end
         S_DONE: req_nxt = 1'b0;
         default: begin
            req_nxt   = 1'b0;
            state_nxt = S_INIT;
         end
      endcase
   end

   always_ff @(posedge gch_clk) begin
      if (gch_reset) begin
         state    <= S_INIT;
         snd0_req <= 1'b0;
         rdy      <= 1'b0;
         o_done   <= 1'b0;
         snd0_dat <= DAT_INIT;
         o_count  <= '0;
      end else begin
         state    <= state_nxt;
         snd0_req <= req_nxt;
         rdy      <= rdy_nxt;
         o_done   <= done_nxt;
         snd0_dat <= dat_nxt;
         o_count  <= count_nxt;
      end
   end

   assign gch_ready = rdy && settled;
   assign snd0_src  = ASZ'(MY_ADDR);
   assign snd0_dst  = ASZ'(DST_ADDR);
   assign snd0_red  = RSZ'(MY_ADDR) + RSZ'(DST_ADDR) + RSZ'(snd0_dat);

endmodule

// File: tb/tb_hcount_source.sv
// Directed-plus-random bench for hcount_source: a finite 4-message instance and a
// free-running 4-bit-data instance, each checked against the expected message sequence.
module tb_hcount_source;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int sel          = 0;

   logic       rst_a, ack_a, ready_a, req_a, done_a;
   logic [7:0] src_a, dst_a, dat_a;
   logic [3:0] red_a;
   logic [15:0] count_a;

   logic       rst_b, ack_b, ready_b, req_b, done_b;
   logic [7:0] src_b, dst_b;
   logic [3:0] dat_b, red_b;
   logic [15:0] count_b;

   hcount_source #(.ASZ(8), .DSZ(8), .RSZ(4), .MY_ADDR(0), .DST_ADDR(1), .START_DAT(0),
                   .NUM_MSGS(4), .CSZ(16), .ACK_CKS(2)) dut_a (
      .gch_clk(clk), .gch_reset(rst_a), .gch_ready(ready_a), .snd0_req(req_a),
      .snd0_ack(ack_a), .snd0_src(src_a), .snd0_dst(dst_a), .snd0_dat(dat_a),
      .snd0_red(red_a), .o_done(done_a), .o_count(count_a));

   hcount_source #(.ASZ(8), .DSZ(4), .RSZ(4), .MY_ADDR(0), .DST_ADDR(1), .START_DAT(14),
                   .NUM_MSGS(0), .CSZ(16), .ACK_CKS(2)) dut_b (
      .gch_clk(clk), .gch_reset(rst_b), .gch_ready(ready_b), .snd0_req(req_b),
      .snd0_ack(ack_b), .snd0_src(src_b), .snd0_dst(dst_b), .snd0_dat(dat_b),
      .snd0_red(red_b), .o_done(done_b), .o_count(count_b));

   logic        req_m, done_m;
   logic [7:0]  dat_m;
   logic [3:0]  red_m;
   logic [15:0] count_m;

   always_comb begin
      req_m   = (sel != 0) ? req_b   : req_a;
      done_m  = (sel != 0) ? done_b  : done_a;
      dat_m   = (sel != 0) ? {4'b0, dat_b} : dat_a;
      red_m   = (sel != 0) ? red_b   : red_a;
      count_m = (sel != 0) ? count_b : count_a;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ack(input logic v);
      if (sel != 0) ack_b = v;
      else          ack_a = v;
   endtask

   task automatic wait_req(input logic lvl, input string tag);
      for (int i = 0; i < 60 && req_m !== lvl; i++) @(negedge clk);
      chk(tag, 32'(req_m), 32'(lvl));
   endtask

   // One complete handshake from the consumer side; expected data/red/count come from the
   // message index, independent of how the DUT sequences it.
   task automatic do_msg(input int delay, input bit glitch, input logic [7:0] exp_dat,
                         input int exp_cnt);
      logic [7:0] exp_red;
      exp_red = (exp_dat + 8'd1) & 8'h0F;
      wait_req(1'b1, "req_rise");
      chk("dat", 32'(dat_m), 32'(exp_dat));
      chk("red", 32'(red_m), 32'(exp_red));
      chk("count", 32'(count_m), exp_cnt);
      chk("done_low", 32'(done_m), 0);
      if (glitch) begin
         set_ack(1'b1);
         @(negedge clk);
         set_ack(1'b0);
         repeat (4) @(negedge clk);
         chk("glitch_req_held", 32'(req_m), 1);
      end
      repeat (delay) begin
         @(negedge clk);
         chk("dat_hold_req", 32'(dat_m), 32'(exp_dat));
      end
      set_ack(1'b1);
      for (int i = 0; i < 60 && req_m !== 1'b0; i++) @(negedge clk);
      chk("req_fall", 32'(req_m), 0);
      chk("dat_hold_fall", 32'(dat_m), 32'(exp_dat));
      repeat (delay) begin
         @(negedge clk);
         chk("dat_hold_ack", 32'(dat_m), 32'(exp_dat));
      end
      set_ack(1'b0);
   endtask

   task automatic check_done4();
      repeat (8) @(negedge clk);
      chk("done_set", 32'(done_a), 1);
      chk("done_count", 32'(count_a), 4);
      chk("done_dat", 32'(dat_a), 4);
      chk("done_req", 32'(req_a), 0);
      chk("done_ready", 32'(ready_a), 1);
      ack_a = 1'b1;
      repeat (6) @(negedge clk);
      ack_a = 1'b0;
      repeat (6) @(negedge clk);
      chk("done_ack_ignored", 32'(req_a), 0);
      chk("done_count_held", 32'(count_a), 4);
   endtask

   initial begin
      int k;
      rst_a = 1'b1; rst_b = 1'b1; ack_a = 1'b0; ack_b = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_req", 32'(req_a), 0);
      chk("rst_count", 32'(count_a), 0);
      chk("rst_done", 32'(done_a), 0);
      chk("rst_dat", 32'(dat_a), 0);
      chk("rst_red", 32'(red_a), 1);
      chk("rst_ready", 32'(ready_a), 0);
      chk("src", 32'(src_a), 0);
      chk("dst", 32'(dst_a), 1);

      // first req exactly two edges after release
      rst_a = 1'b0;
      @(negedge clk);
      chk("req_edge1", 32'(req_a), 0);
      @(negedge clk);
      chk("req_edge2", 32'(req_a), 1);
      chk("ready_edge2", 32'(ready_a), 1);
      for (int n = 0; n < 4; n++) do_msg($urandom_range(0, 4), 1'b0, 8'(n), n);
      check_done4();

      // glitch filtering, slow consumer, then reset in the middle of a handshake
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      do_msg($urandom_range(0, 3), 1'b1, 8'd0, 0);
      do_msg(10, 1'b0, 8'd1, 1);
      wait_req(1'b1, "req_before_midreset");
      chk("count_before_midreset", 32'(count_a), 2);
      rst_a = 1'b1;
      @(negedge clk);
      chk("midrst_req", 32'(req_a), 0);
      chk("midrst_count", 32'(count_a), 0);
      chk("midrst_dat", 32'(dat_a), 0);
      chk("midrst_done", 32'(done_a), 0);
      rst_a = 1'b0;
      for (int n = 0; n < 4; n++) do_msg($urandom_range(0, 4), 1'b0, 8'(n), n);
      check_done4();

      // ack stuck high from reset parks the FSM in LOAD
      ack_a = 1'b1;
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      repeat (4) @(negedge clk);
      chk("stuck_ready", 32'(ready_a), 1);
      chk("stuck_req0", 32'(req_a), 0);
      repeat (10) @(negedge clk);
      chk("stuck_req_later", 32'(req_a), 0);
      ack_a = 1'b0;
      k = 0;
      while (req_a !== 1'b1 && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("drop_req", 32'(req_a), 1);
      chk("drop_latency_ok", 32'(k <= 3), 1);
      do_msg(2, 1'b0, 8'd0, 0);

      // free-running 4-bit instance wraps data and never finishes
      sel = 1;
      @(negedge clk);
      rst_b = 1'b0;
      for (int n = 0; n < 6; n++) do_msg($urandom_range(0, 4), 1'b0, 8'((14 + n) % 16), n);
      repeat (10) @(negedge clk);
      chk("b_done_never", 32'(done_b), 0);
      chk("b_req_next", 32'(req_b), 1);
      chk("b_ready", 32'(ready_b), 1);
      chk("b_count", 32'(count_b), 6);
      chk("b_src_dst", 32'({src_b, dst_b}), 32'h0001);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
